mix_column_sequencer: RTL

//  Time-multiplexes one shared single-column MixColumn engine (enc/dec, XOR-reduced 32b result)

---
 rtl/mix_column_sequencer.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/mix_column_sequencer.sv
// ---------------------------------------------------------------------------
// mix_column_sequencer
//
// Purpose:
//   Time-multiplexes one shared single-column MixColumn engine over the four
//   32-bit columns of a 128-bit AES state. A state is accepted on an
//   in_valid/in_ready handshake, its columns are issued to the engine in
//   order 0..3, the engine results are collected, and the mixed state is
//   returned on an out_valid/out_ready handshake. A bypass path returns the
//   state unmixed (final round) without ever driving the engine.
//
// Parameters:
//   PIPE      0 = engine is combinational, col_out belongs to the column
//                 issued in the same cycle.
//             1 = engine result is registered externally, col_out belongs to
//                 the column issued one cycle earlier.
//
// Ports:
//   clk        in   1    clock, all state on rising edge
//   rst_n      in   1    asynchronous active-low reset
//   in_valid   in   1    input state valid
//   in_ready   out  1    sequencer can accept a state (IDLE only)
//   in_data    in   128  state; column k = in_data[127-32k -: 32]
//   in_dec     in   1    1 = InvMixColumns, 0 = MixColumns (sampled on accept)
//   in_bypass  in   1    1 = pass state through unmixed (sampled on accept)
//   col_in     out  32   column presented to the shared engine (0 when idle)
//   col_dec    out  1    mode presented to the shared engine
//   col_out    in   32   engine result
//   out_valid  out  1    result valid
//   out_ready  in   1    downstream accepts result
//   out_data   out  128  mixed or bypassed state, same ordering as in_data
//   busy       out  1    high in any state other than IDLE
// ---------------------------------------------------------------------------
module mix_column_sequencer #(
    parameter int unsigned PIPE = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    input  logic         in_dec,
    input  logic         in_bypass,
    output logic [31:0]  col_in,
    output logic         col_dec,
    input  logic [31:0]  col_out,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]   r_state;
    logic [1:0]   r_idx;
    logic [127:0] r_src;
    logic [127:0] r_res;
    logic         r_dec;
    logic [31:0]  r_col_in;
    logic         r_in_ready;
    logic         r_out_valid;
    logic         r_busy;

    logic         w_accept;
    logic [1:0]   w_state_nxt;
    logic [1:0]   w_idx_nxt;
    logic [31:0]  w_col_nxt;
    logic         w_wr_en;
    logic [1:0]   w_wr_idx;

    // Column k of a state, column 0 in the most significant word.
    function automatic logic [31:0] col_sel(input logic [127:0] d, input logic [1:0] k);
        logic [31:0] c;
        case (k)
            2'd0:    c = d[127:96];
            2'd1:    c = d[95:64];
            2'd2:    c = d[63:32];
            default: c = d[31:0];
        endcase
        return c;
    endfunction

    assign w_accept = in_valid & r_in_ready;

    // Next-state / issue / write-back decode. col_in is registered, so the
    // column for the next ISSUE cycle is selected here from the next index.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_col_nxt   = '0;
        w_wr_en     = 1'b0;
        w_wr_idx    = r_idx;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (in_bypass) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_state_nxt = S_ISSUE;
                        w_idx_nxt   = 2'd0;
                        w_col_nxt   = in_data[127:96];
                    end
                end
            end
            S_ISSUE: begin
                // With a registered engine the result arriving now belongs
                // to the previous column; column 0's slot carries no result.
                if (PIPE == 0) begin
                    w_wr_en  = 1'b1;
                    w_wr_idx = r_idx;
                end else begin
                    w_wr_en  = (r_idx != 2'd0);
                    w_wr_idx = r_idx - 2'd1;
                end
                if (r_idx == 2'd3) begin
                    w_state_nxt = (PIPE == 0) ? S_DONE : S_DRAIN;
                    w_idx_nxt   = 2'd0;
                end else begin
                    w_idx_nxt = r_idx + 2'd1;
                    w_col_nxt = col_sel(r_src, r_idx + 2'd1);
                end
            end
            S_DRAIN: begin
                w_wr_en     = 1'b1;
                w_wr_idx    = 2'd3;
                w_state_nxt = S_DONE;
            end
            S_DONE: begin
                if (out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // All outputs come straight from registers decoded from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_idx       <= '0;
            r_src       <= '0;
            r_res       <= '0;
            r_dec       <= 1'b0;
            r_col_in    <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_idx       <= w_idx_nxt;
            r_col_in    <= w_col_nxt;
            r_in_ready  <= (w_state_nxt == S_IDLE);
            r_out_valid <= (w_state_nxt == S_DONE);
            r_busy      <= (w_state_nxt != S_IDLE);
            if (w_accept) begin
                r_src <= in_data;
                r_dec <= in_dec;
                if (in_bypass) begin
                    r_res <= in_data;
                end
            end
            if (w_wr_en) begin
                case (w_wr_idx)
                    2'd0:    r_res[127:96] <= col_out;
                    2'd1:    r_res[95:64]  <= col_out;
                    2'd2:    r_res[63:32]  <= col_out;
                    default: r_res[31:0]   <= col_out;
                endcase
            end
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;
    assign col_in    = r_col_in;
    assign col_dec   = r_dec;
    assign out_data  = r_res;

endmodule
